reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_INDEX_BIT, default 4, log2 of entry count (16 entries).
REQ-002 SHALL have clk_in  input  1  system clock, rising edge.
REQ-003 SHALL have rst_n_in  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have rdy_in  input  1  pause; low freezes all state and outputs.
REQ-005 SHALL have issue_valid in 1, issue_type in 2 (REG/STORE/BRANCH/EXIT), issue_rd in 5, issue_pc in 32, issue_pred_taken in 1, issue_alt_pc in 32 (non-predicted path target).
REQ-006 SHALL have issue_rob_id  output  ROB_INDEX_BIT  tail index the next issue receives.
REQ-007 SHALL have full  output  1  no free entry.
REQ-008 SHALL have cdb_valid in 1, cdb_rob_id in ROB_INDEX_BIT, cdb_value in 32, cdb_taken in 1: execution writeback.
REQ-009 SHALL have qry_id1/qry_id2 in ROB_INDEX_BIT, qry_ready1/qry_ready2 out 1, qry_val1/qry_val2 out 32: combinational operand lookup.
REQ-010 SHALL have rf_set_id out 5, rf_set_value out 32, rf_set_rob_id out ROB_INDEX_BIT: register-file commit; id 0 = no write.
REQ-011 SHALL have store_commit out 1, store_rob_id out ROB_INDEX_BIT: store release to load/store buffer.
REQ-012 SHALL have clear out 1, clear_pc out 32: mispredict flush; halt out 1: EXIT committed.

Function
REQ-013 SHALL be a circular buffer with head, tail, count; full = (count == 2^ROB_INDEX_BIT); pointers wrap modulo entry count.
REQ-014 Issue SHALL be accepted iff issue_valid && !full && !clear; entry at tail gets busy=1, ready=0 (EXIT: ready=1), tail increments.
REQ-015 Issue while full SHALL be ignored with no state change; upstream holds the instruction.
REQ-016 cdb_valid SHALL set ready=1, value, taken of entry cdb_rob_id if busy; writeback to non-busy entry ignored.
REQ-017 qry_readyN SHALL be busy&ready of entry qry_idN, or 1 with qry_valN=cdb_value when cdb_valid and cdb_rob_id==qry_idN same cycle.
REQ-018 At most one commit per cycle: head busy&ready -> entry freed, head increments, commit outputs registered (valid the cycle after).
REQ-019 REG/BRANCH commit SHALL drive rf_set_id=rd, rf_set_value=value, rf_set_rob_id=head; rd=0 yields rf_set_id=0.
REQ-020 STORE commit SHALL pulse store_commit one cycle with store_rob_id=head; rf_set_id=0.
REQ-021 BRANCH commit with taken != pred_taken SHALL pulse clear one cycle with clear_pc=alt_pc; no further commit that cycle.
REQ-022 While clear is high: head=tail=count=0, all busy cleared, issue and cdb ignored.
REQ-023 Without a commit, rf_set_id, store_commit, clear SHALL return to 0 next cycle.
REQ-024 Simultaneous issue and commit SHALL leave count unchanged; full is evaluated from start-of-cycle count.
REQ-025 Writeback and commit of the same entry in one cycle: commit SHALL wait one cycle.
REQ-026 EXIT commit SHALL set halt, which stays high until reset; no commits afterwards.

Reset
REQ-027 rst_n_in low SHALL immediately zero head, tail, count, all busy/ready bits, and every output (issue_rob_id=0, full=0, halt=0, clear=0).
REQ-028 First issue after reset release SHALL receive rob id 0.

Configuration
REQ-029 With ROB_DBG_COMMIT_EN defined, outputs dbg_commit (1) and dbg_commit_addr (32) SHALL pulse with every commit carrying the entry pc; without it those ports and their pc storage SHALL not exist.

Structure
REQ-030 ROB_INDEX_BIT, ROB_SIZE and the issue_type codes SHALL live in shared const.v.
REQ-031 Single module with per-entry arrays; no sub-module.

Verification
REQ-032 Issue 3 REG (rd=1,2,3), cdb values 10,20,30 in order -> rf_set_id 1,2,3 with values 10,20,30, rf_set_rob_id 0,1,2 on consecutive cycles.
REQ-033 Issue 16 entries, no writeback -> full=1, 17th issue ignored, issue_rob_id stays 0 after wrap.
REQ-034 BRANCH pred_taken=0, cdb_taken=1, alt_pc=0x100, younger REG issued -> clear pulse with clear_pc=0x100, younger entry never commits, next issue gets rob id 0.
REQ-035 cdb_valid rob_id=2 value 0x55 with qry_id1=2 same cycle -> qry_ready1=1, qry_val1=0x55.
REQ-036 Out-of-order writeback (entry 1 before 0) -> no commit until entry 0 ready, then 0 and 1 commit in order.
REQ-037 Assert rst_n_in mid-stream with 5 busy entries -> all outputs 0 immediately, count 0.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// -----------------------------------------------------------------------------
// reorder_buffer_pkg
//   Shared constants and types for the reorder buffer:
//     ROB_INDEX_BIT_DEF : default log2 of the entry count (16 entries)
//     rob_entries()     : entry count derived from an index width
//     issue_type_e      : instruction class carried by each entry
//     writes_rf()       : true for classes that commit to the register file
// -----------------------------------------------------------------------------
package reorder_buffer_pkg;

  localparam int ROB_INDEX_BIT_DEF = 4;

  typedef enum logic [1:0] {
    TYPE_REG    = 2'd0,
    TYPE_STORE  = 2'd1,
    TYPE_BRANCH = 2'd2,
    TYPE_EXIT   = 2'd3
  } issue_type_e;

  // Entry count is always a power of two so pointers wrap for free.
  function automatic int rob_entries(input int index_bit);
    return 32'sd1 << index_bit;
  endfunction

  // REG and BRANCH (link register) results go to the register file.
  function automatic logic writes_rf(input issue_type_e t);
    return (t == TYPE_REG) || (t == TYPE_BRANCH);
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//   Circular in-order commit buffer for an out-of-order core.
//   Ports:
//     clk_in, rst_n_in (async, active-low), rdy_in (low = freeze everything)
//     issue_*      : allocate the tail entry; issue_rob_id is the id it gets
//     full         : no free entry (issue is ignored, upstream holds it)
//     cdb_*        : execution writeback (ready/value/taken) to a busy entry
//     qry_*        : combinational operand lookup with same-cycle cdb bypass
//     rf_set_*     : registered register-file commit (id 0 = no write)
//     store_*      : registered one-cycle store release
//     clear/clear_pc : registered one-cycle mispredict flush
//     halt         : EXIT committed, sticky until reset
//   Optional feature macro ROB_DBG_COMMIT_EN adds dbg_commit/dbg_commit_addr,
//   a registered commit pulse carrying the committed entry's pc.
// -----------------------------------------------------------------------------
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_INDEX_BIT = ROB_INDEX_BIT_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     issue_valid,
  input  logic [1:0]               issue_type,
  input  logic [4:0]               issue_rd,
  input  logic [31:0]              issue_pc,
  input  logic                     issue_pred_taken,
  input  logic [31:0]              issue_alt_pc,
  output logic [ROB_INDEX_BIT-1:0] issue_rob_id,
  output logic                     full,
  input  logic                     cdb_valid,
  input  logic [ROB_INDEX_BIT-1:0] cdb_rob_id,
  input  logic [31:0]              cdb_value,
  input  logic                     cdb_taken,
  input  logic [ROB_INDEX_BIT-1:0] qry_id1,
  input  logic [ROB_INDEX_BIT-1:0] qry_id2,
  output logic                     qry_ready1,
  output logic                     qry_ready2,
  output logic [31:0]              qry_val1,
  output logic [31:0]              qry_val2,
  output logic [4:0]               rf_set_id,
  output logic [31:0]              rf_set_value,
  output logic [ROB_INDEX_BIT-1:0] rf_set_rob_id,
  output logic                     store_commit,
  output logic [ROB_INDEX_BIT-1:0] store_rob_id,
  output logic                     clear,
  output logic [31:0]              clear_pc,
  output logic                     halt
`ifdef ROB_DBG_COMMIT_EN
  ,
  output logic                     dbg_commit,
  output logic [31:0]              dbg_commit_addr
`endif
);

  localparam int ROB_SIZE = rob_entries(ROB_INDEX_BIT);
  localparam logic [ROB_INDEX_BIT-1:0] IDX_ZERO = {ROB_INDEX_BIT{1'b0}};
  localparam logic [ROB_INDEX_BIT-1:0] IDX_ONE  = {{(ROB_INDEX_BIT-1){1'b0}}, 1'b1};
  localparam logic [ROB_INDEX_BIT:0]   CNT_ZERO = {(ROB_INDEX_BIT+1){1'b0}};
  localparam logic [ROB_INDEX_BIT:0]   CNT_ONE  = {{ROB_INDEX_BIT{1'b0}}, 1'b1};
  localparam logic [ROB_INDEX_BIT:0]   CNT_FULL = {1'b1, {ROB_INDEX_BIT{1'b0}}};

  // Pointers and occupancy
  logic [ROB_INDEX_BIT-1:0] head_r, tail_r;
  logic [ROB_INDEX_BIT:0]   count_r, count_nx_s;

  // Per-entry state
  logic [ROB_SIZE-1:0] busy_r, ready_r, taken_r, pred_r;
  issue_type_e         type_r   [ROB_SIZE];
  logic [4:0]          rd_r     [ROB_SIZE];
  logic [31:0]         value_r  [ROB_SIZE];
  logic [31:0]         alt_pc_r [ROB_SIZE];
`ifdef ROB_DBG_COMMIT_EN
  logic [31:0]         pc_r     [ROB_SIZE];
`else
  logic                unused_pc_s;
  assign unused_pc_s = ^issue_pc;
`endif

  logic        halt_r, clear_r;
  logic        full_s, issue_acc_s, commit_s, mispredict_s, cdb_acc_s;
  issue_type_e head_type_s;

  assign full_s       = (count_r == CNT_FULL);
  assign full         = full_s;
  assign issue_rob_id = tail_r;
  assign halt         = halt_r;
  assign clear        = clear_r;

  // Per-cycle handshake decisions, all from start-of-cycle state
  always_comb begin
    head_type_s  = type_r[head_r];
    issue_acc_s  = issue_valid && !full_s && !clear_r;
    // ready_r is registered, so a writeback to the head commits one cycle later
    commit_s     = busy_r[head_r] && ready_r[head_r] && !halt_r && !clear_r;
    mispredict_s = commit_s && (head_type_s == TYPE_BRANCH) &&
                   (taken_r[head_r] != pred_r[head_r]);
    // The entry being retired this cycle is no longer a writeback target
    cdb_acc_s    = cdb_valid && !clear_r && busy_r[cdb_rob_id] &&
                   !(commit_s && (cdb_rob_id == head_r));
  end

  // Occupancy update: simultaneous issue and commit cancel out
  always_comb begin
    count_nx_s = count_r;
    if (issue_acc_s && !commit_s) begin
      count_nx_s = count_r + CNT_ONE;
    end else if (!issue_acc_s && commit_s) begin
      count_nx_s = count_r - CNT_ONE;
    end else begin
      count_nx_s = count_r;
    end
  end

  // Operand lookup with writeback bypass
  always_comb begin
    qry_ready1 = 1'b0;
    qry_val1   = 32'd0;
    qry_ready2 = 1'b0;
    qry_val2   = 32'd0;
    if (cdb_valid && (cdb_rob_id == qry_id1)) begin
      qry_ready1 = 1'b1;
      qry_val1   = cdb_value;
    end else if (busy_r[qry_id1] && ready_r[qry_id1]) begin
      qry_ready1 = 1'b1;
      qry_val1   = value_r[qry_id1];
    end else begin
      qry_ready1 = 1'b0;
      qry_val1   = 32'd0;
    end
    if (cdb_valid && (cdb_rob_id == qry_id2)) begin
      qry_ready2 = 1'b1;
      qry_val2   = cdb_value;
    end else if (busy_r[qry_id2] && ready_r[qry_id2]) begin
      qry_ready2 = 1'b1;
      qry_val2   = value_r[qry_id2];
    end else begin
      qry_ready2 = 1'b0;
      qry_val2   = 32'd0;
    end
  end

  // Buffer state and registered commit outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_r        <= IDX_ZERO;
      tail_r        <= IDX_ZERO;
      count_r       <= CNT_ZERO;
      busy_r        <= {ROB_SIZE{1'b0}};
      ready_r       <= {ROB_SIZE{1'b0}};
      taken_r       <= {ROB_SIZE{1'b0}};
      pred_r        <= {ROB_SIZE{1'b0}};
      halt_r        <= 1'b0;
      clear_r       <= 1'b0;
      clear_pc      <= 32'd0;
      rf_set_id     <= 5'd0;
      rf_set_value  <= 32'd0;
      rf_set_rob_id <= IDX_ZERO;
      store_commit  <= 1'b0;
      store_rob_id  <= IDX_ZERO;
`ifdef ROB_DBG_COMMIT_EN
      dbg_commit      <= 1'b0;
      dbg_commit_addr <= 32'd0;
`endif
      for (int i = 0; i < ROB_SIZE; i++) begin
        type_r[i]   <= TYPE_REG;
        rd_r[i]     <= 5'd0;
        value_r[i]  <= 32'd0;
        alt_pc_r[i] <= 32'd0;
`ifdef ROB_DBG_COMMIT_EN
        pc_r[i]     <= 32'd0;
`endif
      end
    end else if (rdy_in) begin
      // Pulsed outputs fall back to idle unless a commit drives them
      rf_set_id    <= 5'd0;
      store_commit <= 1'b0;
      clear_r      <= 1'b0;
`ifdef ROB_DBG_COMMIT_EN
      dbg_commit   <= 1'b0;
`endif
      if (commit_s) begin
        busy_r[head_r]  <= 1'b0;
        ready_r[head_r] <= 1'b0;
        head_r          <= head_r + IDX_ONE;
        rf_set_id       <= writes_rf(head_type_s) ? rd_r[head_r] : 5'd0;
        rf_set_value    <= value_r[head_r];
        rf_set_rob_id   <= head_r;
        store_commit    <= (head_type_s == TYPE_STORE);
        if (head_type_s == TYPE_STORE) begin
          store_rob_id <= head_r;
        end
        if (head_type_s == TYPE_EXIT) begin
          halt_r <= 1'b1;
        end
        if (mispredict_s) begin
          clear_r  <= 1'b1;
          clear_pc <= alt_pc_r[head_r];
        end
`ifdef ROB_DBG_COMMIT_EN
        dbg_commit      <= 1'b1;
        dbg_commit_addr <= pc_r[head_r];
`endif
      end
      if (cdb_acc_s) begin
        ready_r[cdb_rob_id] <= 1'b1;
        value_r[cdb_rob_id] <= cdb_value;
        taken_r[cdb_rob_id] <= cdb_taken;
      end
      if (issue_acc_s) begin
        busy_r[tail_r]   <= 1'b1;
        // EXIT has nothing to execute, so it is born ready
        ready_r[tail_r]  <= (issue_type_e'(issue_type) == TYPE_EXIT);
        type_r[tail_r]   <= issue_type_e'(issue_type);
        rd_r[tail_r]     <= issue_rd;
        value_r[tail_r]  <= 32'd0;
        taken_r[tail_r]  <= 1'b0;
        pred_r[tail_r]   <= issue_pred_taken;
        alt_pc_r[tail_r] <= issue_alt_pc;
`ifdef ROB_DBG_COMMIT_EN
        pc_r[tail_r]     <= issue_pc;
`endif
        tail_r           <= tail_r + IDX_ONE;
      end
      count_r <= count_nx_s;
      // A mispredict discards every younger entry, including one issued now
      if (mispredict_s) begin
        head_r  <= IDX_ZERO;
        tail_r  <= IDX_ZERO;
        count_r <= CNT_ZERO;
        busy_r  <= {ROB_SIZE{1'b0}};
        ready_r <= {ROB_SIZE{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//   Directed scenarios followed by randomized traffic, all checked against a
//   queue-based model of an in-order retirement buffer.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

  localparam int SZ = 16;
  localparam logic [1:0] T_REG = 2'd0, T_STORE = 2'd1, T_BR = 2'd2, T_EXIT = 2'd3;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b1, rdy_in = 1'b1;
  logic        issue_valid = 1'b0, issue_pred_taken = 1'b0;
  logic [1:0]  issue_type = 2'd0;
  logic [4:0]  issue_rd = 5'd0;
  logic [31:0] issue_pc = 32'd0, issue_alt_pc = 32'd0;
  logic [3:0]  issue_rob_id;
  logic        full;
  logic        cdb_valid = 1'b0, cdb_taken = 1'b0;
  logic [3:0]  cdb_rob_id = 4'd0;
  logic [31:0] cdb_value = 32'd0;
  logic [3:0]  qry_id1 = 4'd0, qry_id2 = 4'd0;
  logic        qry_ready1, qry_ready2;
  logic [31:0] qry_val1, qry_val2;
  logic [4:0]  rf_set_id;
  logic [31:0] rf_set_value;
  logic [3:0]  rf_set_rob_id;
  logic        store_commit;
  logic [3:0]  store_rob_id;
  logic        clear;
  logic [31:0] clear_pc;
  logic        halt;
`ifdef ROB_DBG_COMMIT_EN
  logic        dbg_commit;
  logic [31:0] dbg_commit_addr;
`endif

  reorder_buffer #(.ROB_INDEX_BIT(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken),
    .issue_alt_pc(issue_alt_pc), .issue_rob_id(issue_rob_id), .full(full),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .cdb_taken(cdb_taken), .qry_id1(qry_id1), .qry_id2(qry_id2),
    .qry_ready1(qry_ready1), .qry_ready2(qry_ready2),
    .qry_val1(qry_val1), .qry_val2(qry_val2),
    .rf_set_id(rf_set_id), .rf_set_value(rf_set_value),
    .rf_set_rob_id(rf_set_rob_id), .store_commit(store_commit),
    .store_rob_id(store_rob_id), .clear(clear), .clear_pc(clear_pc),
    .halt(halt)
`ifdef ROB_DBG_COMMIT_EN
    , .dbg_commit(dbg_commit), .dbg_commit_addr(dbg_commit_addr)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: the buffer is an ordered queue of in-flight instructions
  typedef struct {
    int          id;
    logic [1:0]  typ;
    logic [4:0]  rd;
    logic [31:0] alt;
    bit          pred;
    bit          ready;
    bit          taken;
    logic [31:0] value;
  } ent_t;
  ent_t        rob_q[$];
  int          tail_m;
  bit          halt_m, clear_m, st_m;
  logic [4:0]  rf_id_m;
  logic [31:0] rf_val_m, clear_pc_m;
  int          rf_rob_m, st_rob_m;

  // Observation logs for directed scenarios
  typedef struct {
    int          rd;
    logic [31:0] val;
    int          rob;
    int          cyc;
  } rf_ev_t;
  rf_ev_t      rf_log[$];
  logic [31:0] clr_log[$];
  int          st_log[$];
  int          cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    rob_q.delete();
    tail_m = 0; halt_m = 0; clear_m = 0; st_m = 0;
    rf_id_m = 5'd0; rf_val_m = 32'd0; clear_pc_m = 32'd0;
    rf_rob_m = 0; st_rob_m = 0;
  endtask

  task automatic qry_model(input logic [3:0] id, output bit rdy, output logic [31:0] val);
    rdy = 0;
    val = 32'd0;
    if (cdb_valid && cdb_rob_id == id) begin
      rdy = 1; val = cdb_value;
    end else begin
      foreach (rob_q[k]) begin
        if (rob_q[k].id == int'(id) && rob_q[k].ready) begin
          rdy = 1; val = rob_q[k].value;
        end
      end
    end
  endtask

  task automatic model_step();
    bit   commit, mis, full_now;
    ent_t h, n;
    if (!rdy_in) return;
    full_now = (rob_q.size() == SZ);
    commit   = !halt_m && !clear_m && rob_q.size() > 0 && rob_q[0].ready;
    mis      = 0;
    rf_id_m  = 5'd0;
    st_m     = 0;
    if (commit) begin
      h = rob_q.pop_front();
      rf_id_m  = (h.typ == T_REG || h.typ == T_BR) ? h.rd : 5'd0;
      rf_val_m = h.value;
      rf_rob_m = h.id;
      if (h.typ == T_STORE) begin st_m = 1; st_rob_m = h.id; end
      if (h.typ == T_EXIT) halt_m = 1;
      if (h.typ == T_BR && h.taken != h.pred) begin mis = 1; clear_pc_m = h.alt; end
    end
    if (cdb_valid && !clear_m) begin
      foreach (rob_q[k]) begin
        if (rob_q[k].id == int'(cdb_rob_id)) begin
          rob_q[k].ready = 1; rob_q[k].value = cdb_value; rob_q[k].taken = cdb_taken;
        end
      end
    end
    if (issue_valid && !full_now && !clear_m) begin
      n.id = tail_m; n.typ = issue_type; n.rd = issue_rd; n.alt = issue_alt_pc;
      n.pred = issue_pred_taken; n.ready = (issue_type == T_EXIT);
      n.taken = 0; n.value = 32'd0;
      rob_q.push_back(n);
      tail_m = (tail_m + 1) % SZ;
    end
    if (mis) begin
      rob_q.delete();
      tail_m = 0;
    end
    clear_m = mis;
  endtask

  task automatic compare_outputs();
    check("issue_rob_id", issue_rob_id, tail_m);
    check("full", full, rob_q.size() == SZ);
    check("rf_set_id", rf_set_id, rf_id_m);
    if (rf_id_m != 5'd0) begin
      check("rf_set_value", rf_set_value, rf_val_m);
      check("rf_set_rob_id", rf_set_rob_id, rf_rob_m);
    end
    check("store_commit", store_commit, st_m);
    if (st_m) check("store_rob_id", store_rob_id, st_rob_m);
    check("clear", clear, clear_m);
    if (clear_m) check("clear_pc", clear_pc, clear_pc_m);
    check("halt", halt, halt_m);
  endtask

  // One clock: lookups checked mid-cycle, registered outputs after the edge
  task automatic step();
    bit          er;
    logic [31:0] ev;
    rf_ev_t      e;
    #1;
    qry_model(qry_id1, er, ev);
    check("qry_ready1", qry_ready1, er);
    if (er) check("qry_val1", qry_val1, ev);
    qry_model(qry_id2, er, ev);
    check("qry_ready2", qry_ready2, er);
    if (er) check("qry_val2", qry_val2, ev);
    model_step();
    @(posedge clk_in);
    @(negedge clk_in);
    cyc++;
    compare_outputs();
    if (rf_set_id != 5'd0) begin
      e.rd = rf_set_id; e.val = rf_set_value; e.rob = rf_set_rob_id; e.cyc = cyc;
      rf_log.push_back(e);
    end
    if (clear) clr_log.push_back(clear_pc);
    if (store_commit) st_log.push_back(store_rob_id);
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    cdb_valid   = 1'b0;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd);
    issue_valid = 1'b1; issue_type = t; issue_rd = rd;
    issue_pc = $urandom; issue_pred_taken = 1'b0; issue_alt_pc = $urandom;
    cdb_valid = 1'b0;
    step();
    idle();
  endtask

  task automatic wb(input logic [3:0] id, input logic [31:0] v, input logic tk);
    issue_valid = 1'b0;
    cdb_valid = 1'b1; cdb_rob_id = id; cdb_value = v; cdb_taken = tk;
    step();
    idle();
  endtask

  // Called at a falling edge; reset is asserted mid-phase and checked at once
  task automatic do_reset();
    idle();
    #2 rst_n_in = 1'b0;
    #1;
    check("rst_issue_rob_id", issue_rob_id, 32'd0);
    check("rst_full", full, 32'd0);
    check("rst_halt", halt, 32'd0);
    check("rst_clear", clear, 32'd0);
    check("rst_clear_pc", clear_pc, 32'd0);
    check("rst_rf_set_id", rf_set_id, 32'd0);
    check("rst_rf_set_value", rf_set_value, 32'd0);
    check("rst_store_commit", store_commit, 32'd0);
    check("rst_qry_ready1", qry_ready1, 32'd0);
    check("rst_qry_ready2", qry_ready2, 32'd0);
    model_reset();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    rf_log.delete(); clr_log.delete(); st_log.delete();
  endtask

  initial begin
    int r;
    model_reset();
    do_reset();

    // Three REG instructions written back in order commit on consecutive cycles
    for (int i = 0; i < 3; i++) issue(T_REG, 5'(i + 1));
    wb(4'd0, 32'd10, 1'b0);
    wb(4'd1, 32'd20, 1'b0);
    wb(4'd2, 32'd30, 1'b0);
    for (int i = 0; i < 3; i++) step();
    check("inorder_count", rf_log.size(), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < rf_log.size()) begin
        check("inorder_rd", rf_log[k].rd, k + 1);
        check("inorder_val", rf_log[k].val, 10 * (k + 1));
        check("inorder_rob", rf_log[k].rob, k);
        if (k > 0) check("inorder_consecutive", rf_log[k].cyc - rf_log[k-1].cyc, 32'd1);
      end
    end

    // Same-cycle bypass, then out-of-order writeback retiring in order
    do_reset();
    for (int i = 0; i < 3; i++) issue(T_REG, 5'(i + 4));
    cdb_valid = 1'b1; cdb_rob_id = 4'd2; cdb_value = 32'h55; qry_id1 = 4'd2;
    #1;
    check("bypass_ready", qry_ready1, 32'd1);
    check("bypass_val", qry_val1, 32'h55);
    step();
    idle();
    wb(4'd1, 32'h66, 1'b0);
    step();
    step();
    check("ooo_no_commit", rf_log.size(), 32'd0);
    wb(4'd0, 32'h77, 1'b0);
    for (int i = 0; i < 4; i++) step();
    check("ooo_count", rf_log.size(), 32'd3);
    if (rf_log.size() == 3) begin
      check("ooo_rob0", rf_log[0].rob, 32'd0);
      check("ooo_val0", rf_log[0].val, 32'h77);
      check("ooo_rob1", rf_log[1].rob, 32'd1);
      check("ooo_val1", rf_log[1].val, 32'h66);
      check("ooo_rob2", rf_log[2].rob, 32'd2);
    end

    // Fill to capacity; the 17th issue is ignored
    do_reset();
    for (int i = 0; i < SZ; i++) issue(T_REG, 5'd7);
    check("full_flag", full, 32'd1);
    check("full_wrap_id", issue_rob_id, 32'd0);
    issue(T_REG, 5'd8);
    check("full_ignored_id", issue_rob_id, 32'd0);
    check("full_still", full, 32'd1);

    // Mispredicted branch flushes a ready younger entry
    do_reset();
    issue_valid = 1'b1; issue_type = T_BR; issue_rd = 5'd0; issue_pred_taken = 1'b0;
    issue_alt_pc = 32'h100; issue_pc = 32'h40;
    step();
    idle();
    issue(T_REG, 5'd9);
    wb(4'd1, 32'h99, 1'b0);
    wb(4'd0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) step();
    check("flush_pulses", clr_log.size(), 32'd1);
    if (clr_log.size() == 1) check("flush_pc", clr_log[0], 32'h100);
    check("flush_no_younger", rf_log.size(), 32'd0);
    check("flush_next_id", issue_rob_id, 32'd0);
    issue(T_REG, 5'd10);
    check("flush_after_issue", issue_rob_id, 32'd1);

    // Store release and EXIT halting further commits
    do_reset();
    issue(T_STORE, 5'd0);
    issue(T_REG, 5'd3);
    issue(T_EXIT, 5'd0);
    issue(T_REG, 5'd4);
    wb(4'd0, 32'd0, 1'b0);
    wb(4'd1, 32'd1, 1'b0);
    wb(4'd3, 32'd2, 1'b0);
    for (int i = 0; i < 4; i++) step();
    check("store_pulses", st_log.size(), 32'd1);
    if (st_log.size() == 1) check("store_id", st_log[0], 32'd0);
    check("exit_halt", halt, 32'd1);
    check("exit_commits", rf_log.size(), 32'd1);

    // Pause freezes state
    do_reset();
    issue(T_REG, 5'd2);
    rdy_in = 1'b0;
    issue_valid = 1'b1; issue_type = T_REG; issue_rd = 5'd3;
    cdb_valid = 1'b1; cdb_rob_id = 4'd0; cdb_value = 32'h12;
    for (int i = 0; i < 3; i++) step();
    idle();
    check("pause_id", issue_rob_id, 32'd1);
    rdy_in = 1'b1;
    step();

    // Asynchronous reset with five busy entries
    do_reset();
    for (int i = 0; i < 5; i++) issue(T_REG, 5'd1);
    do_reset();
    issue(T_REG, 5'd1);
    check("post_reset_first_id", rf_set_rob_id, 32'd0);
    check("post_reset_tail", issue_rob_id, 32'd1);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (halt_m && $urandom_range(0, 7) == 0) do_reset();
      rdy_in = ($urandom_range(0, 9) != 0);
      issue_valid = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 99);
      issue_type = (r < 50) ? T_REG : (r < 70) ? T_STORE : (r < 98) ? T_BR : T_EXIT;
      issue_rd = 5'($urandom_range(0, 31));
      issue_pc = $urandom; issue_alt_pc = $urandom;
      issue_pred_taken = 1'($urandom_range(0, 1));
      cdb_valid = ($urandom_range(0, 1) != 0);
      if (rob_q.size() > 0 && $urandom_range(0, 4) != 0)
        cdb_rob_id = 4'(rob_q[$urandom_range(0, rob_q.size() - 1)].id);
      else
        cdb_rob_id = 4'($urandom_range(0, 15));
      cdb_value = $urandom;
      cdb_taken = ($urandom_range(0, 5) == 0) ? ~issue_pred_taken : 1'($urandom_range(0, 1));
      qry_id1 = 4'($urandom_range(0, 15));
      qry_id2 = (rob_q.size() > 0) ? 4'(rob_q[0].id) : 4'($urandom_range(0, 15));
      step();
    end
    idle();
    rdy_in = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
